// File: rtl/led_matrix_scanner.sv
// Double-buffered 8x8 RGB frame store with row-scan driver for active-low column buses.
// Pixels are written into the back buffer; the front buffer is scanned one row per ROW_TICKS.
module led_matrix_scanner #(
  parameter int ROW_TICKS   = 10000,
  parameter int BLANK_TICKS = 16
) (
  input  logic       CLK,
  input  logic       Clear,
  input  logic       wr_en,
  input  logic [2:0] wr_row,
  input  logic [2:0] wr_col,
  input  logic [2:0] wr_rgb,
  input  logic       clr_buf,
  input  logic       swap_req,
  output logic       swap_ack,
  output logic       frame_start,
  output logic [2:0] S,
  output logic [7:0] position_R,
  output logic [7:0] position_G,
  output logic [7:0] position_B
);

  localparam int TW = (ROW_TICKS > 2) ? $clog2(ROW_TICKS) : 1;
  localparam logic [TW-1:0] LAST_TICK = TW'(ROW_TICKS - 1);
  localparam logic [TW-1:0] BLANK_END = TW'(BLANK_TICKS);

  logic [TW-1:0] tick_q, tick_d;
  logic [2:0]    s_q, s_d;
  logic          front_sel_q, pending_q;
  logic          swap_ack_q, frame_start_q;
  logic [7:0]    pos_r_q, pos_g_q, pos_b_q;

  // Colour planes, one bit per pixel, indexed by {row, col}.
  logic [63:0]   red_q [2];
  logic [63:0]   grn_q [2];
  logic [63:0]   blu_q [2];

  logic          row_end, boundary, take_swap, blank, back_sel;

  always_comb begin
    row_end   = (tick_q == LAST_TICK);
    boundary  = row_end && (s_q == 3'd7);
    take_swap = boundary && (pending_q || swap_req);
    blank     = (tick_q < BLANK_END);
    back_sel  = ~front_sel_q;
    tick_d    = row_end ? '0 : tick_q + 1'b1;
    s_d       = row_end ? s_q + 3'd1 : s_q;
  end

  always_ff @(posedge CLK) begin
    if (Clear) begin
      tick_q        <= '0;
      s_q           <= '0;
      front_sel_q   <= 1'b0;
      pending_q     <= 1'b0;
      swap_ack_q    <= 1'b0;
      frame_start_q <= 1'b0;
      pos_r_q       <= 8'hFF;
      pos_g_q       <= 8'hFF;
      pos_b_q       <= 8'hFF;
      red_q[0]      <= '0;
      red_q[1]      <= '0;
      grn_q[0]      <= '0;
      grn_q[1]      <= '0;
      blu_q[0]      <= '0;
      blu_q[1]      <= '0;
    end else begin
      tick_q        <= tick_d;
      s_q           <= s_d;
      frame_start_q <= boundary;
      swap_ack_q    <= take_swap;

      if (boundary) begin
        pending_q <= 1'b0;
        if (take_swap) front_sel_q <= ~front_sel_q;
      end else if (swap_req) begin
        pending_q <= 1'b1;
      end

      // Columns lag tick/S by one cycle, so the blank window covers the row change.
      if (blank) begin
        pos_r_q <= 8'hFF;
        pos_g_q <= 8'hFF;
        pos_b_q <= 8'hFF;
      end else begin
        pos_r_q <= ~red_q[front_sel_q][{s_q, 3'b000} +: 8];
        pos_g_q <= ~grn_q[front_sel_q][{s_q, 3'b000} +: 8];
        pos_b_q <= ~blu_q[front_sel_q][{s_q, 3'b000} +: 8];
      end

      // Back is chosen by the pre-swap front_sel, so a boundary-cycle write lands in the new front.
      if (clr_buf) begin
        red_q[back_sel] <= '0;
        grn_q[back_sel] <= '0;
        blu_q[back_sel] <= '0;
      end else if (wr_en) begin
        red_q[back_sel][{wr_row, wr_col}] <= wr_rgb[2];
        grn_q[back_sel][{wr_row, wr_col}] <= wr_rgb[1];
        blu_q[back_sel][{wr_row, wr_col}] <= wr_rgb[0];
      end
    end
  end

  assign swap_ack    = swap_ack_q;
  assign frame_start = frame_start_q;
  assign S           = s_q;
  assign position_R  = pos_r_q;
  assign position_G  = pos_g_q;
  assign position_B  = pos_b_q;

endmodule

// File: tb/tb_led_matrix_scanner.sv
// Directed bench for led_matrix_scanner with ROW_TICKS=8, BLANK_TICKS=2 (64-cycle frames).
module tb_led_matrix_scanner;

  logic       CLK = 1'b0;
  logic       Clear = 1'b1;
  logic       wr_en = 1'b0;
  logic [2:0] wr_row = '0;
  logic [2:0] wr_col = '0;
  logic [2:0] wr_rgb = '0;
  logic       clr_buf = 1'b0;
  logic       swap_req = 1'b0;
  logic       swap_ack, frame_start;
  logic [2:0] S;
  logic [7:0] position_R, position_G, position_B;

  int n_vec = 0;
  int n_bad = 0;
  int k = 0;        // state index since the last reset release
  int acks = 0;

  led_matrix_scanner #(.ROW_TICKS(8), .BLANK_TICKS(2)) dut (
    .CLK(CLK), .Clear(Clear), .wr_en(wr_en), .wr_row(wr_row), .wr_col(wr_col),
    .wr_rgb(wr_rgb), .clr_buf(clr_buf), .swap_req(swap_req), .swap_ack(swap_ack),
    .frame_start(frame_start), .S(S), .position_R(position_R),
    .position_G(position_G), .position_B(position_B)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s (k=%0d): got %0h, expected %0h", tag, k, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
    k++;
  endtask

  task automatic run_to(input int kt);
    while (k < kt) step();
  endtask

  task automatic check_off(input string tag);
    check({tag, "_R"}, position_R, 8'hFF);
    check({tag, "_G"}, position_G, 8'hFF);
    check({tag, "_B"}, position_B, 8'hFF);
  endtask

  initial begin
    // 1. reset
    step(); step();
    Clear = 1'b0;
    k = 0;
    check("rst_S", S, 3'd0);
    check_off("rst");
    check("rst_ack", swap_ack, 1'b0);
    check("rst_fs", frame_start, 1'b0);

    // 2. scan timing over ~3 frames, buffers empty
    while (k < 199) begin
      step();
      check("scan_S", S, (k / 8) % 8);
      check("scan_fs", frame_start, (k % 64) == 0);
      check("scan_ack", swap_ack, 1'b0);
      if ((k % 8) == 1 || (k % 8) == 2) check("scan_blank", position_R, 8'hFF);
    end

    // 3. one red pixel at row 2 col 5, then swap
    run_to(200);
    wr_en = 1'b1; wr_row = 3'd2; wr_col = 3'd5; wr_rgb = 3'b100;
    step();
    wr_en = 1'b0;
    swap_req = 1'b1;
    step();
    swap_req = 1'b0;
    while (k < 256) begin
      check_off("preswap");
      check("preswap_ack", swap_ack, 1'b0);
      step();
    end
    check("swap_ack", swap_ack, 1'b1);
    check("swap_fs", frame_start, 1'b1);
    run_to(268); check("row1_R", position_R, 8'hFF);
    run_to(273); check("row2_blank_R", position_R, 8'hFF);
    run_to(276);
    check("row2_R", position_R, 8'b1101_1111);
    check("row2_G", position_G, 8'hFF);
    check("row2_B", position_B, 8'hFF);
    run_to(280); check("row2_last_R", position_R, 8'b1101_1111);

    // 4a. three requests in one frame give one swap (front becomes the empty buffer)
    acks = 0;
    while (k < 384) begin
      swap_req = (k == 290 || k == 295 || k == 300);
      if (swap_ack) acks++;
      if (k == 340) check("after_swap_R", position_R, 8'hFF);
      step();
    end
    swap_req = 1'b0;
    check("one_ack", acks, 1);
    check("no_ack_next", swap_ack, 1'b0);
    check("fs_next", frame_start, 1'b1);

    // 4b. request only in the 7->0 cycle
    run_to(404); check("old_img_R", position_R, 8'hFF);
    run_to(447);
    check("pre_bound_ack", swap_ack, 1'b0);
    swap_req = 1'b1;
    step();
    swap_req = 1'b0;
    check("bound_ack", swap_ack, 1'b1);
    check("bound_fs", frame_start, 1'b1);
    run_to(468); check("new_img_R", position_R, 8'b1101_1111);

    // 5. fill back buffer, then clr_buf with a colliding write, then swap
    run_to(470);
    for (int i = 0; i < 64; i++) begin
      wr_en = 1'b1; wr_row = 3'(i / 8); wr_col = 3'(i % 8); wr_rgb = 3'b111;
      if (k == 532) check("front_kept_R", position_R, 8'b1101_1111);
      step();
    end
    wr_row = 3'd0; wr_col = 3'd0; wr_rgb = 3'b111;
    clr_buf = 1'b1;
    step();
    wr_en = 1'b0; clr_buf = 1'b0;
    swap_req = 1'b1;
    step();
    swap_req = 1'b0;
    run_to(576);
    check("clr_swap_ack", swap_ack, 1'b1);
    while (k < 640) begin
      step();
      check_off("cleared");
    end

    // 6. reset with swap pending at row 4
    run_to(650);
    swap_req = 1'b1;
    step();
    swap_req = 1'b0;
    run_to(674);
    check("pre_clr_S", S, 3'd4);
    Clear = 1'b1;
    step();
    Clear = 1'b0;
    k = 0;
    check("mid_rst_S", S, 3'd0);
    check_off("mid_rst");
    check("mid_rst_fs", frame_start, 1'b0);
    check("mid_rst_ack", swap_ack, 1'b0);
    acks = 0;
    while (k < 64) begin
      step();
      if (swap_ack) acks++;
      if (k == 7) check("mid_rst_S7", S, 3'd0);
      if (k == 8) check("mid_rst_S8", S, 3'd1);
    end
    check("mid_rst_bound_fs", frame_start, 1'b1);
    check("mid_rst_bound_ack", swap_ack, 1'b0);
    check("mid_rst_acks", acks, 0);
    run_to(84); check_off("mid_rst_row2");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/led_matrix_scanner.md
Name: led_matrix_scanner

Overview:
Double-buffered frame store and scan driver for the 8x8 RGB LED matrix. Game logic writes individual pixels into a back buffer and requests a swap. The block reads the front buffer one row at a time and drives the row select and the active-low R/G/B column buses. It replaces hand-multiplexed column muxing in game top levels with a single reader of a pixel-addressed frame.

Parameters:
ROW_TICKS, 10000, CLK cycles each row is selected (must be >= 2)
BLANK_TICKS, 16, cycles at start of each row with all columns forced off (must be < ROW_TICKS)

Ports:
CLK  input  1  system clock
Clear  input  1  synchronous active-high reset
wr_en  input  1  write one pixel of back buffer this cycle
wr_row  input  3  pixel row (0..7)
wr_col  input  3  pixel column (0..7)
wr_rgb  input  3  {R,G,B}, 1 = lit
clr_buf  input  1  clear entire back buffer this cycle
swap_req  input  1  request front/back exchange at next frame boundary
swap_ack  output  1  one-cycle pulse: swap performed
frame_start  output  1  one-cycle pulse: row 0 begins
S  output  3  row select
position_R  output  8  red columns, active-low, bit c = column c
position_G  output  8  green columns, active-low
position_B  output  8  blue columns, active-low

Behaviour:
- Reset (Clear high at a CLK edge), effective next cycle:
  - S=0, tick=0, front_sel=0, pending=0.
  - swap_ack=0, frame_start=0.
  - position_R/G/B=8'hFF.
  - Both buffers all zero.
- Clear mid-frame aborts the row and any pending swap. Clear has priority over every other input.
- Storage: two 8x8x3 register arrays. Front = buf[front_sel]; back = buf[~front_sel].
- Write: wr_en stores wr_rgb at back[wr_row][wr_col] at the edge. No read-back port. Front is never written.
- clr_buf zeroes all 64 back pixels in one cycle. clr_buf and wr_en in the same cycle: clr_buf wins, the write is dropped.
- Row timer: tick counts 0..ROW_TICKS-1.
  - At tick==ROW_TICKS-1: tick to 0, S to (S+1) mod 8. Row 7 wraps to 0.
- Column outputs (registered, 1-cycle latency from tick/S):
  - tick < BLANK_TICKS: all three buses 8'hFF.
  - Otherwise position_X[c] = ~front[S][c].X.
  - The blanking window prevents ghosting while S changes.
- Frame boundary: the edge where S goes 7->0.
  - frame_start pulses 1 cycle, aligned with the first cycle of S=0.
  - No frame_start after reset until the first 7->0 wrap.
- Swap handshake:
  - swap_req sets pending. Further swap_req while pending is ignored; no queueing.
  - At a boundary, if (pending | swap_req): front_sel toggles, pending clears, swap_ack pulses with frame_start.
  - A swap_req in the boundary cycle itself is taken at that boundary.
  - The new front is shown from row 0 of the new frame. It is never shown mid-frame.
- Write in the swap cycle: addresses back per the pre-swap front_sel, so it lands in the buffer that becomes front.
- No copy on swap: the new back holds the previous front's contents. Software must clr_buf or rewrite it.
- wr_en and clr_buf are legal at any time, including during blanking, swap pending and boundary.

Test Plan:
(ROW_TICKS=8, BLANK_TICKS=2 unless stated.)
1. Reset:
   - Stimulus: hold Clear 2 cycles, release.
   - Required: S=0, position_R/G/B=8'hFF, swap_ack=0, frame_start=0.
   - Required: first frame_start exactly 64 cycles after release.
2. Scan timing:
   - Stimulus: free-run 200 cycles.
   - Required: S steps 0..7, each held 8 cycles.
   - Required: first 2 output cycles of every row = 8'hFF; frame_start period 64.
3. Pixel/swap:
   - Stimulus: write (row2,col5,rgb=3'b100), then swap_req.
   - Required: swap_ack coincident with next frame_start.
   - Required: row 2 unblanked output position_R=8'b11011111, G=B=8'hFF.
   - Required: the frame before the swap shows all FF.
4. Swap edge cases:
   - Stimulus: swap_req three times mid-frame.
   - Required: exactly one swap_ack.
   - Stimulus: swap_req only in the 7->0 cycle.
   - Required: swap_ack in that boundary; new image from row 0.
5. Clear priority:
   - Stimulus: write full back buffer, then wr_en plus clr_buf in the same cycle, then swap.
   - Required: displayed frame all 8'hFF.
6. Mid-frame reset:
   - Stimulus: swap pending, S=4, assert Clear one cycle.
   - Required: next cycle S=0, tick=0, outputs FF, pending dropped.
   - Required: no swap_ack at the following boundary.
